seg7_scan_scheduler: RTL and testbench
======================================

// Module: seg7_scan_scheduler
// PURPOSE
//  Owns the 8-digit 7-segment display and time-shares it between three sources:
//  the score, the key-event history and a game-over banner.
//  Arbitrates which source owns each frame, then scans the digits with anti-ghost blanking.
//  Records the last 4 PS/2 key events from the game_clk domain.
//  Sits in game_top in place of direct 7-seg drive.
// PARAMETERS
//  DIGIT_CYCLES     100_000      CLK100MHZ cycles per digit slot (1 ms; 125 Hz frame rate)
//  BLANK_CYCLES     1_000        cycles at end of each slot with all digits off; must be < DIGIT_CYCLES
//  KEY_HOLD_CYCLES  200_000_000  how long KEY mode persists after the last key event (2 s)
// PORTS
//  CLK100MHZ   in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  key_valid   in   1   key-event pulse, game_clk domain (>=4 CLK100MHZ cycles wide)
//  scan_code   in   8   scan code; stable while key_valid is high
//  make_break  in   1   1 = make, 0 = break; stable while key_valid is high
//  score       in   32  game score, game_clk domain; sampled only at frame start
//  game_over   in   1   game-over level, game_clk domain
//  SEG         out  7   segments, active low, {g,f,e,d,c,b,a}
//  AN          out  8   digit anodes, active low, one-hot or all-off
//  DP          out  1   decimal point, active low
// BEHAVIOUR
//  Reset values: AN=8'hFF, SEG=7'h7F, DP=1, mode=SCORE, digit=0, scan state=DRIVE.
//   All history entries are invalid after reset. All outputs are registered.
//  Sync: key_valid and game_over each pass through a 2-flop synchronizer.
//   A rising edge of synced key_valid is one event.
//   On an event, capture {make_break, scan_code} and shift it into a 4-entry history.
//   Entry 0 is the newest; the oldest entry drops out.
//   An event also reloads the hold counter to KEY_HOLD_CYCLES-1.
//  Hold counter: decrements to 0 and saturates there.
//  Scan FSM: DRIVE then BLANK, slot counter 0..DIGIT_CYCLES-1.
//   DRIVE covers cycles 0..DIGIT_CYCLES-BLANK_CYCLES-1:
//    AN[digit]=0, SEG and DP come from the current source.
//   BLANK covers the remaining cycles: AN=8'hFF, SEG=7'h7F, DP=1.
//   At slot end, digit increments 0..7 and wraps. The wrap from 7 to 0 is the frame boundary.
//  Arbitration: evaluated only at a frame boundary, so a frame is never torn.
//   Priority: synced game_over=1 -> OVER; else hold counter !=0 -> KEY; else SCORE.
//   The score is snapshotted into a 32-bit register at the same boundary.
//  Digit content (digit 7 = leftmost):
//   SCORE: hex of score snapshot.
//    Leading zeros are blanked; digit 0 is always shown (score 0 shows a single "0").
//   KEY: digits 2k+1..2k show history entry (3-k) in hex, so entry 0 sits on digits 7..6.
//    DP on the even digit of an entry is lit when that entry is a make.
//    Invalid entries are blank.
//   OVER: digits 7..5 show "E","n","d"; digit 4 is blank; digits 3..0 show snapshot[15:0] in hex.
//  DP is off in all modes except KEY.
//  Simultaneous events:
//   A key event on a frame boundary is captured, and that same arbitration counts it.
//   Events during OVER are still recorded and reload the hold counter.
//   If game_over has fallen and the hold counter is still !=0, KEY mode follows.
//  Back-to-back events 1 cycle apart after sync cannot occur; events are never dropped.
//  Reset mid-frame: outputs go to reset values on the next edge and scanning restarts at digit 0.
// STRUCTURE
//  Glyph constants go in the shared package src/GLOBAL.sv:
//   SEG_BLANK, SEG_E, SEG_n, SEG_d, and hex glyphs 0-F.
//  Mode enum: disp_mode_t {MODE_SCORE, MODE_KEY, MODE_OVER}.
//  One sub-module, seg7_hex_decoder: combinational 4-bit nibble -> 7-bit active-low glyph.
//  Top level holds the synchronizers, history shift register, hold counter, scan FSM and arbiter.
// TESTING (bench uses DIGIT_CYCLES=16, BLANK_CYCLES=2, KEY_HOLD_CYCLES=1000)
//  Reset, then idle -> AN walks FE,FD,..,7F.
//   Each digit is low for 14 cycles, then AN=FF for 2 cycles.
//   Score 0 -> only digit 0 shows 7'h40.
//  score=32'h0000_1A3F -> digits 3..0 show 1,A,3,F; digits 7..4 AN pulses occur but SEG=7F.
//  key_valid 4-cycle pulse, scan 8'h6B, make=1 -> KEY mode from the next frame.
//   Digits 7,6 show 6,B with DP=0 on digit 6.
//   1000 cycles later the following frame is SCORE.
//  Five events 11,22,33,44,55 -> digits 7..0 show 55 44 33 22.
//   Entry 11 is gone; a break entry shows DP=1.
//  game_over=1 during KEY hold -> next frame shows E,n,d,blank,score[15:0].
//   A new key event while OVER changes nothing visible.
//  Assert rst mid-slot on digit 5 -> next cycle AN=FF, SEG=7F.
//   Scan resumes at digit 0 and history is cleared.

Source files
------------

// File: rtl/seg7_scan_scheduler_pkg.sv
// seg7_scan_scheduler_pkg: glyphs, display modes and scan states shared by the 7-seg scheduler
package seg7_scan_scheduler_pkg;
  typedef enum logic [1:0] {MODE_SCORE, MODE_KEY, MODE_OVER} disp_mode_t;
  typedef enum logic {S_DRIVE, S_BLANK} scan_state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_n = 7'h2B;
  localparam logic [6:0] SEG_d = 7'h21;
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg7_scan_scheduler_hex_decoder.sv
// seg7_hex_decoder: 4-bit nibble to active-low {g,f,e,d,c,b,a} glyph
module seg7_hex_decoder
  import seg7_scan_scheduler_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[nib];
endmodule

// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler: frame-arbitrated score/key-history/game-over scan of an 8-digit 7-seg display
module seg7_scan_scheduler
  import seg7_scan_scheduler_pkg::*;
#(
  parameter int DIGIT_CYCLES    = 100_000,
  parameter int BLANK_CYCLES    = 1_000,
  parameter int KEY_HOLD_CYCLES = 200_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  scan_code,
  input  logic        make_break,
  input  logic [31:0] score,
  input  logic        game_over,
  output logic [6:0]  SEG,
  output logic [7:0]  AN,
  output logic        DP
);
  localparam int CW = $clog2(DIGIT_CYCLES + 1);
  localparam int HW = $clog2(KEY_HOLD_CYCLES + 1);
  logic [1:0] kv_sync, go_sync;
  logic kv_q, key_ev;
  logic [3:0][8:0] hist;
  logic [3:0] hist_vld;
  logic [HW-1:0] hold;
  logic [CW-1:0] cnt;
  logic [2:0] digit;
  scan_state_t state, state_n;
  disp_mode_t mode, mode_n;
  logic [31:0] snap;
  logic slot_end, frame_end, ent_vld, lead_zero, dp_on;
  logic [8:0] entry;
  logic [3:0] nib;
  logic [6:0] hex_seg, over_glyph, glyph;

  assign key_ev = kv_sync[1] & ~kv_q;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      kv_sync  <= '0;
      go_sync  <= '0;
      kv_q     <= 1'b0;
      hist     <= '0;
      hist_vld <= '0;
      hold     <= '0;
    end else begin
      kv_sync <= {kv_sync[0], key_valid};
      go_sync <= {go_sync[0], game_over};
      kv_q    <= kv_sync[1];
      if (key_ev) begin
        hist     <= {hist[2:0], {make_break, scan_code}};
        hist_vld <= {hist_vld[2:0], 1'b1};
        hold     <= HW'(KEY_HOLD_CYCLES - 1);
      end else if (hold != '0) begin
        hold <= hold - 1'b1;
      end
    end
  end

  always_comb begin
    slot_end  = cnt == CW'(DIGIT_CYCLES - 1);
    frame_end = slot_end && digit == 3'd7;
    state_n   = slot_end ? S_DRIVE : (cnt == CW'(DIGIT_CYCLES - BLANK_CYCLES - 1)) ? S_BLANK : state;
    // an event landing on the boundary edge already counts toward KEY
    mode_n    = go_sync[1] ? MODE_OVER : (key_ev || hold != '0) ? MODE_KEY : MODE_SCORE;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state <= S_DRIVE;
      cnt   <= '0;
      digit <= '0;
      mode  <= MODE_SCORE;
      snap  <= '0;
    end else begin
      state <= state_n;
      cnt   <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) digit <= digit + 1'b1;
      if (frame_end) begin
        mode <= mode_n;
        snap <= score;
      end
    end
  end

  always_comb begin
    entry      = hist[~digit[2:1]];
    ent_vld    = hist_vld[~digit[2:1]];
    lead_zero  = digit != 3'd0 && (snap >> {digit, 2'b00}) == 32'd0;
    nib        = (mode == MODE_KEY) ? (digit[0] ? entry[7:4] : entry[3:0]) : snap[{digit, 2'b00} +: 4];
    over_glyph = digit == 3'd7 ? SEG_E : digit == 3'd6 ? SEG_n : digit == 3'd5 ? SEG_d :
                 digit == 3'd4 ? SEG_BLANK : hex_seg;
    glyph      = (mode == MODE_KEY) ? (ent_vld ? hex_seg : SEG_BLANK) :
                 (mode == MODE_OVER) ? over_glyph : (lead_zero ? SEG_BLANK : hex_seg);
    dp_on      = mode == MODE_KEY && ent_vld && !digit[0] && entry[8];
  end

  seg7_hex_decoder u_hex (.nib(nib), .seg(hex_seg));

  always_ff @(posedge CLK100MHZ) begin
    if (rst || state == S_BLANK) begin
      AN  <= 8'hFF;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      AN  <= ~(8'd1 << digit);
      SEG <= glyph;
      DP  <= ~dp_on;
    end
  end
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb_seg7_scan_scheduler: randomized scoreboard bench with a frame-level reference model
module tb_seg7_scan_scheduler;
  localparam int DC = 16, BC = 2, KH = 1000, FRAME = 8 * DC;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic CLK100MHZ = 0, rst = 1, key_valid = 0, make_break = 0, game_over = 0;
  logic [7:0] scan_code = 0;
  logic [31:0] score = 0;
  logic [6:0] SEG;
  logic [7:0] AN;
  logic DP;

  seg7_scan_scheduler #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .KEY_HOLD_CYCLES(KH)) dut (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .key_valid(key_valid), .scan_code(scan_code),
    .make_break(make_break), .score(score), .game_over(game_over),
    .SEG(SEG), .AN(AN), .DP(DP)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {int t; logic [31:0] v;} tv_t;
  typedef struct {logic [7:0] an; logic [6:0] seg; logic dp;} exp_t;
  tv_t key_q[$], go_q[$], sc_q[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int cyc = 0, r = 0, checks = 0, errors = 0, pk, run = 0, idle = 0;
  bit model_on = 0, mon_en = 0;
  logic [7:0] prev_an = 8'hFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // expected glyph of digit d in the frame whose boundary edge is b
  function automatic exp_t expect_digit(int b, int d, bit first);
    exp_t e;
    logic [31:0] snap, code;
    logic [31:0] h[$];
    bit go, key;
    int ent;
    logic [3:0] nib;
    snap = 0; go = 0; key = 0;
    if (!first) begin
      foreach (sc_q[i]) if (sc_q[i].t <= b) snap = sc_q[i].v;
      foreach (go_q[i]) if (go_q[i].t <= b) go = go_q[i].v[0];
      foreach (key_q[i]) if (key_q[i].t <= b && key_q[i].t > b - KH) key = 1;
    end
    foreach (key_q[i]) if (key_q[i].t <= b + DC * d) h.push_front(key_q[i].v);
    e.an = ~(8'd1 << d);
    e.dp = 1'b1;
    nib = snap[4*d +: 4];
    e.seg = (d != 0 && (snap >> (4 * d)) == 0) ? 7'h7F : HEX[nib];
    if (go) e.seg = d == 7 ? 7'h06 : d == 6 ? 7'h2B : d == 5 ? 7'h21 : d == 4 ? 7'h7F : HEX[nib];
    else if (key) begin
      ent = 3 - d / 2;
      if (ent < h.size()) begin
        code = h[ent];
        e.seg = HEX[(d % 2 == 1) ? code[7:4] : code[3:0]];
        e.dp = !(d % 2 == 0 && code[8]);
      end else e.seg = 7'h7F;
    end
    return e;
  endfunction

  always @(posedge CLK100MHZ) begin
    cyc++;
    if (model_on && cyc > r && (cyc - r - 1) % DC == 0) begin
      pk = (cyc - r - 1) / DC;
      exp_q.push_back(expect_digit(r + FRAME * (pk / 8), pk % 8, pk < 8));
    end
  end

  always @(negedge CLK100MHZ) begin
    if (!mon_en) begin
      prev_an = 8'hFF; run = 0; idle = 0;
    end else begin
      if (AN != 8'hFF) begin
        if (prev_an == 8'hFF) begin
          if (exp_q.size() == 0) chk("digit_unexpected", AN, 8'hFF);
          else begin
            mon_e = exp_q.pop_front();
            chk("an", AN, mon_e.an);
            chk("seg", SEG, mon_e.seg);
            chk("dp", DP, mon_e.dp);
          end
          run = 0; idle = 0;
        end
        run++;
      end else begin
        if (prev_an != 8'hFF) begin
          chk("drive_len", run, DC - BC);
          chk("blank_seg_dp", {DP, SEG}, 8'hFF);
        end
        idle++;
        if (idle > 3 * DC) begin
          chk("scan_stall", idle, 0);
          idle = 0;
        end
      end
      prev_an = AN;
    end
  end

  task automatic do_reset();
    if (!rst) begin
      @(posedge CLK100MHZ); #1;
      rst = 1; mon_en = 0; model_on = 0;
    end
    repeat (3) @(posedge CLK100MHZ);
    #1;
    chk("reset_outputs", {DP, SEG, AN}, 16'hFFFF);
    exp_q.delete(); key_q.delete(); go_q.delete(); sc_q.delete();
    sc_q.push_back('{0, score});
    go_q.push_back('{0, {31'd0, game_over}});
    r = cyc; rst = 0; model_on = 1; mon_en = 1;
  endtask

  task automatic key_event(input logic [7:0] sc, input logic mb);
    @(posedge CLK100MHZ); #1;
    key_valid = 1; scan_code = sc; make_break = mb;
    key_q.push_back('{cyc + 3, {23'd0, mb, sc}});
    repeat (4) @(posedge CLK100MHZ);
    #1 key_valid = 0;
    repeat (4) @(posedge CLK100MHZ);
  endtask

  task automatic set_score(input logic [31:0] v);
    @(posedge CLK100MHZ); #1;
    score = v;
    sc_q.push_back('{cyc + 1, v});
  endtask

  task automatic set_go(input logic v);
    @(posedge CLK100MHZ); #1;
    game_over = v;
    go_q.push_back('{cyc + 3, {31'd0, v}});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK100MHZ);
  endtask

  initial begin
    do_reset();
    wait_cycles(2 * FRAME);
    set_score(32'h0000_1A3F);
    wait_cycles(2 * FRAME);
    key_event(8'h6B, 1'b1);
    wait_cycles(KH + 2 * FRAME);
    for (int i = 1; i <= 5; i++) key_event(8'(8'h11 * i), 1'(i % 2));
    wait_cycles(KH + FRAME);
    // key event whose capture lands exactly on a frame boundary
    do begin @(posedge CLK100MHZ); #1; end while ((cyc - r) % FRAME != FRAME - 4);
    key_event(8'hC4, 1'b1);
    wait_cycles(2 * FRAME);
    set_score($urandom);
    key_event(8'hA5, 1'b1);
    wait_cycles(FRAME / 2);
    set_go(1'b1);
    wait_cycles(2 * FRAME);
    key_event(8'h3C, 1'b0);
    wait_cycles(2 * FRAME);
    set_go(1'b0);
    wait_cycles(2 * FRAME);
    wait_cycles(KH);
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0: set_score($urandom);
        1: set_score($urandom & 32'h0000_0FFF);
        2: key_event(8'($urandom), 1'($urandom));
        default: set_go(i % 5 == 2);
      endcase
      wait_cycles($urandom_range(10, 300));
    end
    set_go(1'b0);
    wait_cycles(KH + 2 * FRAME);
    key_event(8'h5A, 1'b1);
    key_event(8'h12, 1'b0);
    for (int i = 0; i < 300 && AN != 8'hDF; i++) @(negedge CLK100MHZ);
    chk("find_digit5", AN, 8'hDF);
    repeat (5) @(posedge CLK100MHZ);
    #1;
    rst = 1; mon_en = 0; model_on = 0;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    chk("midrst_an", AN, 8'hFF);
    chk("midrst_seg_dp", {DP, SEG}, 8'hFF);
    do_reset();
    wait_cycles(FRAME);
    key_event(8'hE7, 1'b1);
    wait_cycles(3 * FRAME);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
